// File: rtl/perf_counter_snapshot_master_if.sv
// Bus bundle for the snapshot master: Avalon-MM master side towards the
// counter slave and the valid/ready stream towards the trace sink.
interface perf_counter_snapshot_master_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       snap_data;
  logic [ADDR_W-1:0] snap_index;
  logic              snap_valid;
  logic              snap_ready;
  logic              snap_last;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest,
    output snap_data, snap_index, snap_valid, snap_last,
    input  snap_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest,
    input  snap_data, snap_index, snap_valid, snap_last,
    output snap_ready
  );
endinterface

// File: rtl/perf_counter_snapshot_master.sv
// Reads every section's time lo/hi and event counter on a trigger and streams
// the words out. Optional macro PERF_SNAPSHOT_FREEZE_EN brackets the dump with
// a freeze write (addr 0) and a resume write (addr 1) for a coherent snapshot.
module perf_counter_snapshot_master #(
  parameter int NUM_SECTIONS = 4,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       trigger_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] dropped_triggers_o,
  perf_counter_snapshot_master_if.master bus
);

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LATENCY);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(4 * (NUM_SECTIONS - 1) + 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef PERF_SNAPSHOT_FREEZE_EN
    FRZ_WR  = 3'd1,
    RES_WR  = 3'd5,
`endif
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [7:0]        drop_q, drop_d;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] bus_addr;

  // Word 4s+2 is the last read of a section; 4s+3 is skipped.
  assign next_addr = (addr_q[1:0] == 2'd2) ? (addr_q + ADDR_W'(2)) : (addr_q + ADDR_W'(1));

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    data_d  = data_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          addr_d  = '0;
`ifdef PERF_SNAPSHOT_FREEZE_EN
          state_d = FRZ_WR;
`else
          state_d = RD_REQ;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef PERF_SNAPSHOT_FREEZE_EN
      FRZ_WR: begin
        if (!bus.avm_waitrequest) begin
          state_d = RD_REQ;
        end else begin
          state_d = FRZ_WR;
        end
      end
      RES_WR: begin
        if (!bus.avm_waitrequest) begin
          state_d = DONE;
        end else begin
          state_d = RES_WR;
        end
      end
`endif
      RD_REQ: begin
        if (!bus.avm_waitrequest) begin
          lat_d   = LAT_INIT;
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (lat_q <= LAT_W'(1)) begin
          data_d  = bus.avm_readdata;
          index_d = addr_q;
          lat_d   = '0;
          state_d = OUT;
        end else begin
          lat_d   = lat_q - LAT_W'(1);
        end
      end
      OUT: begin
        if (bus.snap_ready) begin
          if (addr_q == LAST_ADDR) begin
`ifdef PERF_SNAPSHOT_FREEZE_EN
            state_d = RES_WR;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d  = next_addr;
            state_d = RD_REQ;
          end
        end else begin
          state_d = OUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Triggers that arrive while a snapshot is running are only counted.
  always_comb begin
    drop_d = drop_q;
    if (trigger_i && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      data_q  <= 32'd0;
      index_q <= '0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      index_q <= index_d;
      drop_q  <= drop_d;
    end
  end

  // Address is driven only while a bus request is active, zero otherwise.
  always_comb begin
    bus_addr = '0;
    case (state_q)
      RD_REQ:  bus_addr = addr_q;
`ifdef PERF_SNAPSHOT_FREEZE_EN
      RES_WR:  bus_addr = ADDR_W'(1);
`endif
      default: bus_addr = '0;
    endcase
  end

  assign busy_o             = (state_q != IDLE);
  assign done_o             = (state_q == DONE);
  assign dropped_triggers_o = drop_q;

  assign bus.avm_address   = bus_addr;
  assign bus.avm_read      = (state_q == RD_REQ);
`ifdef PERF_SNAPSHOT_FREEZE_EN
  assign bus.avm_write     = (state_q == FRZ_WR) || (state_q == RES_WR);
`else
  assign bus.avm_write     = 1'b0;
`endif
  assign bus.avm_writedata = 32'd0;

  assign bus.snap_data  = data_q;
  assign bus.snap_index = index_q;
  assign bus.snap_valid = (state_q == OUT);
  assign bus.snap_last  = (state_q == OUT) && (index_q == LAST_ADDR);

endmodule

// File: tb/tb_perf_counter_snapshot_master.sv
// Self-checking bench: Avalon slave model with latency 1 plus a scoreboard of
// expected snapshot words filled at trigger time and drained on each handshake.
module tb_perf_counter_snapshot_master;
  localparam int NS = 4;
  localparam int AW = 4;
  localparam int NW = 3 * NS;
`ifdef PERF_SNAPSHOT_FREEZE_EN
  localparam int FRZ = 1;
`else
  localparam int FRZ = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic       busy, done;
  logic [7:0] dropped;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_rd = 0;
  logic [31:0] mem [0:15];
  logic [31:0] rd_q = 32'd0;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;
  exp_t sb[$];

  perf_counter_snapshot_master_if #(.ADDR_W(AW)) bus();

  perf_counter_snapshot_master #(
    .NUM_SECTIONS(NS), .READ_LATENCY(1), .ADDR_W(AW)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .trigger_i(trigger),
    .busy_o(busy), .done_o(done), .dropped_triggers_o(dropped),
    .bus(bus)
  );

  assign bus.avm_readdata = rd_q;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: fixed latency of one cycle after an accepted read.
  always @(posedge clk) begin
    if (bus.avm_read && !bus.avm_waitrequest) begin
      rd_q <= mem[bus.avm_address];
      n_rd <= n_rd + 1;
    end
`ifdef PERF_SNAPSHOT_FREEZE_EN
    if (bus.avm_write && !bus.avm_waitrequest && bus.avm_address == 4'd1) begin
      mem[2] <= mem[2] + 32'd1;
    end
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drain the scoreboard on every stream handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.snap_valid && bus.snap_ready) begin
      check_eq("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("snap_data", bus.snap_data, e.data);
        check_eq("snap_index", {28'd0, bus.snap_index}, {28'd0, e.idx});
        check_eq("snap_last", {31'd0, bus.snap_last}, {31'd0, e.last});
      end
    end
    if (bus.avm_read || bus.avm_write)
      check_eq("rw_excl", {31'd0, bus.avm_read & bus.avm_write}, 32'd0);
  end

  task automatic push_expected();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < 3; w++) begin
        exp_t e;
        e.data = mem[4*s + w];
        e.idx  = AW'(4*s + w);
        e.last = (s == NS - 1) && (w == 2);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_snap(output int t);
    @(posedge clk); #1;
    trigger = 1'b1;
    t = cyc;
    push_expected();
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic wait_read(input logic [AW-1:0] a);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.avm_read && bus.avm_address == a) && n < 300);
    check_eq("wait_read", {31'd0, bus.avm_read && bus.avm_address == a}, 32'd1);
  endtask

  task automatic wait_valid(input logic [AW-1:0] a);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.snap_valid && bus.snap_index == a) && n < 300);
    check_eq("wait_valid", {31'd0, bus.snap_valid && bus.snap_index == a}, 32'd1);
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!done && n < 400);
    check_eq("done_seen", {31'd0, done}, 32'd1);
    t = cyc;
  endtask

  initial begin
    int t, td, rd0;
    logic ok;
    logic [31:0] hold_d;
    for (int s = 0; s < 4; s++) begin
      mem[4*s]     = 32'h1000_0000 + 32'(s);
      mem[4*s + 1] = 32'h2000_0000 + 32'(s);
      mem[4*s + 2] = 32'h3000_0000 + 32'(s);
      mem[4*s + 3] = 32'hDEAD_0000 + 32'(s);
    end
    mem[0] = 32'hFFFF_FFF0;
    mem[1] = 32'h0000_0001;
    mem[2] = 32'h0000_0007;
    bus.avm_waitrequest = 1'b0;
    bus.snap_ready      = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.snap_valid}, 32'd0);
    check_eq("rst_read", {31'd0, bus.avm_read}, 32'd0);
    check_eq("rst_write", {31'd0, bus.avm_write}, 32'd0);
    check_eq("rst_dropped", {24'd0, dropped}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic snapshot and latency
    start_snap(t);
    @(negedge clk);
`ifdef PERF_SNAPSHOT_FREEZE_EN
    check_eq("first_op_wr", {31'd0, bus.avm_write}, 32'd1);
    check_eq("first_op_wdata", bus.avm_writedata, 32'd0);
`else
    check_eq("first_op_rd", {31'd0, bus.avm_read}, 32'd1);
`endif
    check_eq("first_op_addr", {28'd0, bus.avm_address}, 32'd0);
    check_eq("busy_t1", {31'd0, busy}, 32'd1);
    repeat (2 + FRZ) @(negedge clk);
    check_eq("valid_t3", {31'd0, bus.snap_valid}, 32'd1);
    check_eq("first_data", bus.snap_data, 32'hFFFF_FFF0);
    wait_done(td);
    check_eq("done_latency", 32'(td - t), 32'(37 + 2*FRZ));
    check_eq("sb_empty1", 32'(sb.size()), 32'd0);
    check_eq("reads1", 32'(n_rd), 32'(NW));

    // Waitrequest stall on idx4, then sink stall on idx9
    rd0 = n_rd;
    start_snap(t);
    wait_valid(4'd2);
    bus.avm_waitrequest = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      ok &= bus.avm_read && (bus.avm_address == 4'd4);
    end
    check_eq("waitreq_hold", {31'd0, ok}, 32'd1);
    bus.avm_waitrequest = 1'b0;
    wait_read(4'd9);
    bus.snap_ready = 1'b0;
    wait_valid(4'd9);
    hold_d = bus.snap_data;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      ok &= bus.snap_valid && (bus.snap_data == hold_d) && (bus.snap_index == 4'd9) && !bus.avm_read;
    end
    check_eq("ready_hold", {31'd0, ok}, 32'd1);
    bus.snap_ready = 1'b1;
    wait_done(td);
    check_eq("sb_empty2", 32'(sb.size()), 32'd0);
    check_eq("reads2", 32'(n_rd - rd0), 32'(NW));

    // Dropped triggers, trigger in DONE cycle, restart right after done
    start_snap(t);
    repeat (3) begin
      @(posedge clk); #1; trigger = 1'b1;
      @(posedge clk); #1; trigger = 1'b0;
    end
    @(negedge clk);
    check_eq("dropped3", {24'd0, dropped}, 32'd3);
    wait_valid(4'd14);
    @(posedge clk);
    repeat (FRZ) @(posedge clk);
    #1 trigger = 1'b1;
    @(negedge clk);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    t = cyc;
    push_expected();
    @(negedge clk);
    check_eq("dropped_done", {24'd0, dropped}, 32'd4);
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    bus.snap_ready = 1'b0;
    repeat (260) @(posedge clk);
    #1 trigger = 1'b0;
    bus.snap_ready = 1'b1;
    @(negedge clk);
    check_eq("dropped_sat", {24'd0, dropped}, 32'd255);
    wait_done(td);
    check_eq("sb_empty3", 32'(sb.size()), 32'd0);

    // Reset during RD_WAIT of idx5
    start_snap(t);
    wait_read(4'd5);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_valid", {31'd0, bus.snap_valid}, 32'd0);
    check_eq("mid_read", {31'd0, bus.avm_read}, 32'd0);
    check_eq("mid_write", {31'd0, bus.avm_write}, 32'd0);
    check_eq("mid_data", bus.snap_data, 32'd0);
    check_eq("mid_index", {28'd0, bus.snap_index}, 32'd0);
    check_eq("mid_dropped", {24'd0, dropped}, 32'd0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    start_snap(t);
    wait_done(td);
    check_eq("sb_empty4", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/perf_counter_snapshot_master.md
Name: perf_counter_snapshot_master

Overview:
- Avalon-MM master that drives the performance-counter control slave from the other side of the bus.
- On a trigger it reads every section's time counter (lo, hi) and event counter word, then streams each word out on a valid/ready interface.
- Sits between a trigger source (timer or debug logic) and a trace/logging sink, so counter dumps need no CPU involvement.

Parameters:
- NUM_SECTIONS, 4: sections read per snapshot (1..4); section s occupies word addresses 4s..4s+3.
- READ_LATENCY, 1: fixed slave read latency in cycles (>=1) after a read is accepted.
- ADDR_W, 4: width of avm_address (word address).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trigger  in  1  single-cycle pulse; starts a snapshot when idle
- busy  out  1  high from trigger acceptance through the done pulse
- done  out  1  one-cycle pulse after the last word handshakes (and after the resume write when the freeze feature is present)
- dropped_triggers  out  8  saturating count of triggers seen while busy
- avm_address  out  ADDR_W  word address
- avm_read  out  1  read request
- avm_write  out  1  write request (freeze feature only; tied 0 otherwise)
- avm_writedata  out  32  write data (always 0)
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall; request is accepted in the cycle waitrequest is low
- snap_data  out  32  captured counter word
- snap_index  out  ADDR_W  address the word was read from
- snap_valid  out  1  word available
- snap_ready  in  1  sink accepts the word when valid && ready
- snap_last  out  1  high with the final word of the snapshot

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; dropped_triggers 0.
- Read sequence per section s, in order: 4s (time lo), 4s+1 (time hi), 4s+2 (event).
  - Total words per snapshot: 3*NUM_SECTIONS (12 at default).
- FSM states: IDLE, FRZ_WR, RD_REQ, RD_WAIT, OUT, RES_WR, DONE.
  - IDLE: on trigger go to RD_REQ (or FRZ_WR with the feature); busy=1 from the next cycle.
  - RD_REQ: assert avm_read with the current address. Hold address and read stable while avm_waitrequest=1. Once accepted, go to RD_WAIT and load the latency counter with READ_LATENCY.
  - RD_WAIT: decrement the counter. On the edge where it expires (end of cycle A+READ_LATENCY, A = accept cycle), capture avm_readdata into snap_data and snap_index, then go to OUT.
  - OUT: snap_valid=1; data and index hold stable until the handshake.
    - On handshake, if this was not the last word: advance the address and go to RD_REQ.
    - On handshake of the last word: go to RES_WR (with the feature) or DONE.
  - DONE: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Exactly one read outstanding; no new read is issued until the previous word has handshaked.
- Default-latency timing, no stalls, snap_ready tied 1:
  - trigger in cycle T; avm_read in T+1; snap_valid in T+3.
  - Each subsequent word takes 3 cycles, so 12 words take 36 cycles; done in T+37.
- snap_last = snap_valid && (word is event word of section NUM_SECTIONS-1).
- A trigger while busy (including during the DONE cycle) is ignored and increments dropped_triggers, saturating at 255. A trigger in IDLE is accepted.
- avm_read and avm_write are never asserted together.
- Reset mid-operation: the FSM returns to IDLE next edge and snap_valid drops immediately, without completing the handshake. No resume write is issued. dropped_triggers clears.

Optional Feature:
- Macro: PERF_SNAPSHOT_FREEZE_EN.
- Defined (coherent snapshot):
  - FRZ_WR: write address 0 with writedata 0. This stops section 0 and therefore the global enable, freezing all time counters. Held until accepted.
  - RES_WR: after the last word, write address 1 to restart section 0. Held until accepted, then go to DONE.
  - Documented side effect: each snapshot increments event counter 0 by 1.
- Undefined:
  - avm_write is tied 0; FRZ_WR and RES_WR are removed.
  - Counters keep running during the dump, so lo/hi words may be torn.

Test Plan:
- Slave model with READ_LATENCY 1, time_counter_0=0x00000001_FFFFFFF0, event_counter_0=7, snap_ready=1; trigger -> first three words 0xFFFFFFF0/idx0, 0x00000001/idx1, 0x00000007/idx2; 12 words total; snap_last only on idx14; done at T+37.
- avm_waitrequest high for 5 cycles on the idx4 read -> avm_address holds 4 and avm_read stays high throughout; exactly one read accepted; data correct.
- snap_ready low for 10 cycles on word idx9 -> snap_data and snap_index hold stable; no avm_read issued meanwhile; sequence resumes at idx10.
- Three triggers during busy -> dropped_triggers=3; after 258 such triggers -> 255; a trigger one cycle after done starts a new snapshot.
- Reset asserted during RD_WAIT of idx5 -> next cycle all outputs 0, IDLE; a following trigger restarts at idx0.
- With PERF_SNAPSHOT_FREEZE_EN: first bus op is a write to addr 0, data 0; last is a write to addr 1; time counters read back-to-back show equal values; event counter 0 increments by 1 per snapshot.
